mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/scc_mem_pkg.sv | 15 +
 rtl/arb_starve_sel.sv | 42 ++++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scc_mem_pkg.sv
// Shared types and default parameters for the fetch/data memory arbiter.
package scc_mem_pkg;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/arb_starve_sel.sv
// Winner select between fetch and data, with a starvation counter that hands
// the port to fetch after STARVE_LIMIT consecutive contested losses.
module arb_starve_sel
    import scc_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int CNT_W        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_arb_en,
    input  logic i_fetch_req,
    input  logic i_data_req,
    output logic o_grant_fetch,
    output logic o_grant_data
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_force_fetch;

    always_comb begin
        w_force_fetch = i_fetch_req && (r_starve_cnt == LIMIT_C);
        o_grant_data  = i_data_req && !w_force_fetch;
        o_grant_fetch = i_fetch_req && !o_grant_data;
    end

    // Counts only contested arbitrations that data wins; saturates at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (i_arb_en) begin
            if (o_grant_fetch) begin
                r_starve_cnt <= '0;
            end else if (i_fetch_req && o_grant_data && (r_starve_cnt != LIMIT_C)) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// state | meaning: IDLE arbitrate | BUSY_I fetch on port | BUSY_D data on port | RESP pulse valid/done
module mem_arbiter
    import scc_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_mem_en,
    input  logic [ADDR_W-1:0] in_mem_addr,
    output logic [DATA_W-1:0] in_mem,
    output logic              in_mem_valid,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] data_in,
    output logic              data_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic              r_resp_fetch;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_in_mem;
    logic [DATA_W-1:0] r_data_in;
    logic              w_data_req;
    logic              w_arb_en;
    logic              w_grant_fetch;
    logic              w_grant_data;

    assign w_data_req = data_read | data_write;
    assign w_arb_en   = (r_state == ST_IDLE);

    arb_starve_sel #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_sel (
        .clk           (clk),
        .reset         (reset),
        .i_arb_en      (w_arb_en),
        .i_fetch_req   (in_mem_en),
        .i_data_req    (w_data_req),
        .o_grant_fetch (w_grant_fetch),
        .o_grant_data  (w_grant_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        mem_req      = 1'b0;
        in_mem_valid = 1'b0;
        data_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_data) begin
                    w_next = ST_BUSY_D;
                end else if (w_grant_fetch) begin
                    w_next = ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
                if (r_resp_fetch) begin
                    in_mem_valid = 1'b1;
                end else begin
                    data_done = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request fields are latched at the grant so the port stays stable even if
    // the requester changes or drops its inputs mid-access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we         <= 1'b0;
            r_resp_fetch <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_in_mem     <= '0;
            r_data_in    <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (w_grant_data) begin
                    r_we         <= data_write;
                    r_addr       <= data_addr;
                    r_wdata      <= data_out;
                    r_resp_fetch <= 1'b0;
                end else if (w_grant_fetch) begin
                    r_we         <= 1'b0;
                    r_addr       <= in_mem_addr;
                    r_resp_fetch <= 1'b1;
                end
            end
            if (mem_ready && (r_state == ST_BUSY_I)) begin
                r_in_mem <= mem_rdata;
            end
            if (mem_ready && (r_state == ST_BUSY_D) && !r_we) begin
                r_data_in <= mem_rdata;
            end
        end
    end

    assign mem_we    = mem_req && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign in_mem    = r_in_mem;
    assign data_in   = r_data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random requesters, a memory responder and a
// rule-level arbitration/memory model feeding an expected-response queue.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_mem_en;
    logic [AW-1:0] in_mem_addr;
    logic [DW-1:0] in_mem;
    logic          in_mem_valid;
    logic          data_read;
    logic          data_write;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_out;
    logic [DW-1:0] data_in;
    logic          data_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_mem_en    (in_mem_en),
        .in_mem_addr  (in_mem_addr),
        .in_mem       (in_mem),
        .in_mem_valid (in_mem_valid),
        .data_read    (data_read),
        .data_write   (data_write),
        .data_addr    (data_addr),
        .data_out     (data_out),
        .data_in      (data_in),
        .data_done    (data_done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: model view and device view are kept separately.
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] dev_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] dev_read(input logic [AW-1:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return 32'h0000_1000 + 32'($urandom_range(0, 31)) * 4;
    endfunction

    typedef struct {
        bit            is_fetch;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    typedef enum int {P_ARB, P_BUSY, P_RESP, P_POST} mphase_t;

    txn_t          exp_q[$];
    bit            grant_log[$];
    txn_t          cur;
    txn_t          t;
    mphase_t       phase = P_ARB;
    int            losses = 0;
    int            rdy_mode = 0;
    int            rdy_wait = 0;
    int            busy_len = 0;
    int            last_busy_len = 0;
    int            n_valid = 0;
    int            n_done = 0;
    logic [DW-1:0] exp_in_mem = '0;
    logic [DW-1:0] exp_data_in = '0;

    // Monitor + memory responder: checks at negedge, drives mem_ready for this cycle.
    initial begin
        bit any;
        bit fw;
        bit rdy;
        bit handled;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (in_mem_valid) n_valid++;
            if (data_done)    n_done++;
            if (reset) begin
                chk("rst_mem_req", mem_req, 0);
                chk("rst_pulses", {in_mem_valid, data_done}, 0);
                chk("rst_in_mem", in_mem, 0);
                chk("rst_data_in", data_in, 0);
                phase = P_ARB;
                losses = 0;
                exp_q.delete();
                exp_in_mem = '0;
                exp_data_in = '0;
                mem_ready = 1'b0;
                continue;
            end
            handled = 1'b0;
            if (phase == P_RESP) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    t = exp_q.pop_front();
                    chk("resp_valid", in_mem_valid, t.is_fetch);
                    chk("resp_done", data_done, !t.is_fetch);
                    if (t.is_fetch) exp_in_mem = t.rdata;
                    else if (!t.we) exp_data_in = t.rdata;
                end
                chk("resp_mem_req", mem_req, 0);
                phase = P_POST;
            end else begin
                chk("no_pulse", {in_mem_valid, data_done}, 0);
                if (phase == P_POST) begin
                    chk("post_resp_no_grant", mem_req, 0);
                    phase = P_ARB;
                end else if (phase == P_ARB) begin
                    any = in_mem_en | data_read | data_write;
                    chk("grant_timing", mem_req, any);
                    if (any) begin
                        fw = in_mem_en && (!(data_read | data_write) || losses == LIM);
                        if (fw) losses = 0;
                        else if (in_mem_en) losses = (losses < LIM) ? losses + 1 : LIM;
                        cur.is_fetch = fw;
                        cur.we       = fw ? 1'b0 : data_write;
                        cur.addr     = fw ? in_mem_addr : data_addr;
                        cur.wdata    = data_out;
                        if (cur.we) ref_mem[cur.addr] = cur.wdata;
                        cur.rdata    = cur.we ? '0 : ref_read(cur.addr);
                        exp_q.push_back(cur);
                        grant_log.push_back(fw);
                        phase = P_BUSY;
                        busy_len = 0;
                    end
                end
                if (phase == P_BUSY) begin
                    handled = 1'b1;
                    busy_len++;
                    chk("busy_req", mem_req, 1);
                    chk("busy_addr", mem_addr, cur.addr);
                    chk("busy_we", mem_we, cur.we);
                    if (cur.we) chk("busy_wdata", mem_wdata, cur.wdata);
                    case (rdy_mode)
                        1:       rdy = 1'b1;
                        2:       rdy = (busy_len > rdy_wait);
                        3:       rdy = 1'b0;
                        default: rdy = ($urandom_range(0, 99) < 50);
                    endcase
                    mem_ready = rdy;
                    mem_rdata = $urandom;
                    if (rdy) begin
                        if (mem_we) dev_mem[mem_addr] = mem_wdata;
                        else        mem_rdata = dev_read(mem_addr);
                        last_busy_len = busy_len;
                        phase = P_RESP;
                    end
                end
            end
            if (!handled) begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            chk("in_mem_hold", in_mem, exp_in_mem);
            chk("data_in_hold", data_in, exp_data_in);
        end
    end

    // Fetch requester.
    int            f_budget = 0;
    int            f_prob = 0;
    bit            f_fixed = 0;
    logic [AW-1:0] f_fix_addr = '0;

    initial begin
        in_mem_en = 1'b0;
        in_mem_addr = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                in_mem_en = 1'b0;
                continue;
            end
            if (in_mem_en && in_mem_valid) in_mem_en = 1'b0;
            if (!in_mem_en && f_budget > 0 && $urandom_range(0, 99) < f_prob) begin
                f_budget--;
                in_mem_en = 1'b1;
                in_mem_addr = f_fixed ? f_fix_addr : rand_addr();
            end
        end
    end

    // Data requester; op 1 read, 2 write, 3 read+write, 0 random.
    int            d_budget = 0;
    int            d_prob = 0;
    int            d_op = 0;
    bit            d_fixed = 0;
    logic [AW-1:0] d_fix_addr = '0;
    logic [DW-1:0] d_fix_data = '0;

    initial begin
        int op;
        data_read = 1'b0;
        data_write = 1'b0;
        data_addr = '0;
        data_out = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                data_read = 1'b0;
                data_write = 1'b0;
                continue;
            end
            if ((data_read || data_write) && data_done) begin
                data_read = 1'b0;
                data_write = 1'b0;
            end
            if (!(data_read || data_write) && d_budget > 0 && $urandom_range(0, 99) < d_prob) begin
                d_budget--;
                op = (d_op == 0) ? int'($urandom_range(1, 3)) : d_op;
                data_read  = (op != 2);
                data_write = (op != 1);
                data_addr  = d_fixed ? d_fix_addr : rand_addr();
                data_out   = d_fixed ? d_fix_data : $urandom;
            end
        end
    end

    task automatic wait_done(input string name, input bit fetch, input int limit, output int n);
        for (n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (fetch ? in_mem_valid : data_done) break;
        end
        checks++;
        if (n > limit) begin
            errors++;
            $display("FAIL %s: no completion within %0d cycles", name, limit);
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        for (n = 0; n < limit; n++) begin
            @(negedge clk);
            if (f_budget == 0 && d_budget == 0 && !in_mem_en && !data_read && !data_write &&
                phase == P_ARB && exp_q.size() == 0) break;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL %s: traffic did not drain within %0d cycles", name, limit);
        end
        repeat (2) @(negedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n0;
        bit exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_mem_req", mem_req, 0);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        chk("reset_in_mem", in_mem, 0);
        chk("reset_data_in", data_in, 0);
        chk("reset_valid_done", {in_mem_valid, data_done}, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #2;

        // Single fetch, immediate ready.
        rdy_mode = 1;
        ref_mem[32'h100] = 32'hE3A0_0001;
        dev_mem[32'h100] = 32'hE3A0_0001;
        f_fixed = 1; f_fix_addr = 32'h100; f_prob = 100; f_budget = 1;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 2) begin
                chk("fetch_req_cycle1", mem_req, 1);
                chk("fetch_addr", mem_addr, 32'h100);
                chk("fetch_we", mem_we, 0);
            end
            if (in_mem_valid) break;
        end
        chk("fetch_latency", n, 3);
        chk("fetch_data", in_mem, 32'hE3A0_0001);
        f_fixed = 0;
        wait_drain("fetch_drain", 50);

        // Write with three wait states, then read it back.
        rdy_mode = 2; rdy_wait = 3;
        n0 = n_done;
        d_fixed = 1; d_fix_addr = 32'h2000; d_fix_data = 32'hDEAD_BEEF; d_op = 2; d_prob = 100; d_budget = 1;
        wait_done("write_done", 0, 40, n);
        wait_drain("write_drain", 50);
        chk("write_busy_len", last_busy_len, 4);
        chk("write_done_once", n_done - n0, 1);
        chk("write_mem", dev_read(32'h2000), 32'hDEAD_BEEF);
        rdy_mode = 1; d_op = 1; d_budget = 1;
        wait_done("readback_done", 0, 40, n);
        #1;
        chk("readback_data", data_in, 32'hDEAD_BEEF);
        wait_drain("readback_drain", 50);

        // Both held continuously: fetch wins every fifth contested arbitration.
        grant_log.delete();
        d_fixed = 0; d_op = 1; f_prob = 100; d_prob = 100;
        f_budget = 2; d_budget = 12;
        for (n = 0; n < 200 && grant_log.size() < 10; n++) @(negedge clk);
        chk("starve_grants_seen", grant_log.size() >= 10, 1);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            chk($sformatf("starve_order_%0d", i), grant_log[i], exp_seq[i]);
        wait_drain("starve_drain", 300);

        // Read and write together behave as a write.
        d_fixed = 1; d_fix_addr = 32'h3000; d_fix_data = 32'h1234_5678; d_op = 3; d_budget = 1;
        wait_done("both_done", 0, 40, n);
        wait_drain("both_drain", 50);
        chk("both_write_mem", dev_read(32'h3000), 32'h1234_5678);

        // Reset while a data read waits on the memory.
        rdy_mode = 3; d_op = 1; d_fix_addr = 32'h2000; d_budget = 1;
        for (n = 0; n < 20 && !mem_req; n++) @(negedge clk);
        chk("reset_txn_started", mem_req, 1);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_mem_req", mem_req, 0);
        chk("async_rst_mem_addr", mem_addr, 0);
        chk("async_rst_data_in", data_in, 0);
        n0 = n_done;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        rdy_mode = 1;
        repeat (6) @(negedge clk);
        chk("no_done_after_reset", n_done, n0);
        #2;
        f_fixed = 1; f_fix_addr = 32'h100; f_budget = 1;
        wait_done("post_reset_fetch", 1, 20, n);
        #1;
        chk("post_reset_fetch_data", in_mem, 32'hE3A0_0001);
        f_fixed = 0; d_fixed = 0;
        wait_drain("post_reset_drain", 50);

        // Random traffic with random memory wait states.
        rdy_mode = 0; d_op = 0; f_prob = 30; d_prob = 30;
        f_budget = 200; d_budget = 200;
        wait_drain("random_drain", 20000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
